// File: rtl/regfile_param.sv
// Parametrised register file: one write port, two combinational read ports,
// optional bypass and hardwired-zero R0, plus a one-register-per-cycle clear.
module regfile_param #(
    parameter int WIDTH   = 16,
    parameter int ADDR_W  = 3,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] dest,
    input  logic [WIDTH-1:0]  w_in,
    input  logic              w_en,
    input  logic [ADDR_W-1:0] src0,
    input  logic [ADDR_W-1:0] src1,
    output logic [WIDTH-1:0]  op0,
    output logic [WIDTH-1:0]  op1,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } clr_state_e;

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];

    logic sweep;
    logic wr_acc;

    assign sweep  = (state_q == SWEEP);
    assign wr_acc = w_en && !sweep &&
                    !((ZERO_R0 != 0) && (dest == '0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        clr_busy = 1'b0;
        clr_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = SWEEP;
                    ptr_d   = '0;
                end
            end
            SWEEP: begin
                clr_busy = 1'b1;
                ptr_d    = ptr_q + 1'b1;
                if (ptr_q == {ADDR_W{1'b1}}) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                clr_done = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    // Sweep and write never coincide: writes are blocked while sweeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (sweep) begin
            mem_q[ptr_q] <= '0;
        end else if (wr_acc) begin
            mem_q[dest] <= w_in;
        end
    end

    always_comb begin
        op0 = mem_q[src0];
        if ((BYPASS != 0) && wr_acc && (src0 == dest)) begin
            op0 = w_in;
        end
        if ((ZERO_R0 != 0) && (src0 == '0)) begin
            op0 = '0;
        end
    end

    always_comb begin
        op1 = mem_q[src1];
        if ((BYPASS != 0) && wr_acc && (src1 == dest)) begin
            op1 = w_in;
        end
        if ((ZERO_R0 != 0) && (src1 == '0)) begin
            op1 = '0;
        end
    end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
Parametrised successor to the fixed 8x16 processor register file. Width and depth are configurable. It has one write port and two combinational read ports, with optional write-to-read bypass and an optional hardwired-zero R0. A sequenced bulk-clear engine zeroes the file one register per cycle under a busy/done handshake, so the control unit can reinitialise state without asserting global reset. Sits between the decode stage (register addresses) and the ALU/writeback path.

Parameters:
WIDTH, 16, data width of each register and of w_in/op0/op1
ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers
BYPASS, 1, 1 = a same-cycle write is forwarded to any read port addressing the written register
ZERO_R0, 0, 1 = register 0 always reads 0 and writes to it are dropped

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
dest  input  ADDR_W  write address
w_in  input  WIDTH  write data
w_en  input  1  write enable
src0  input  ADDR_W  read address, port 0
src1  input  ADDR_W  read address, port 1
op0  output  WIDTH  read data, port 0 (combinational)
op1  output  WIDTH  read data, port 1 (combinational)
clr_req  input  1  bulk-clear request, sampled on clk
clr_busy  output  1  high while the clear sweep is in progress
clr_done  output  1  one-cycle pulse when the sweep completes

Behaviour:
- One clock (clk); reset asynchronous, active-high.
- Reset forces:
  - all DEPTH registers to 0
  - FSM to IDLE and sweep pointer to 0
  - clr_busy=0 and clr_done=0
  - op0/op1 therefore read 0.
- Write acceptance: at a clk rising edge, reg[dest] <= w_in if all of the following hold:
  - w_en=1
  - FSM is not in SWEEP
  - not (ZERO_R0=1 and dest=0)
- Reads are combinational, zero cycles latency. opN = reg[srcN], with two overrides in priority order:
  - ZERO_R0=1 and srcN=0: opN=0.
  - BYPASS=1, write accepted this cycle and srcN=dest: opN=w_in.
  - BYPASS=0: a newly written value appears on opN the cycle after the write edge.
- Both read ports are independent. src0=src1 is legal and yields identical data.
- Clear FSM states: IDLE, SWEEP, DONE.
  - IDLE: clr_req=1 at edge E moves to SWEEP with ptr=0. Otherwise stay.
  - SWEEP: clr_busy=1. At each edge, reg[ptr] <= 0 and ptr <= ptr+1. The edge that clears reg[DEPTH-1] moves to DONE; ptr wraps to 0.
  - DONE: clr_done=1 for exactly one cycle. The next edge returns to IDLE.
- Sweep timing, with request sampled at edge E:
  - clr_busy is high for the DEPTH cycles following E.
  - reg[i] is cleared at edge E+1+i.
  - clr_done is high for the cycle following edge E+DEPTH.
  - Total request-to-idle time is DEPTH+2 edges.
- clr_req is ignored in SWEEP and DONE; no queuing. A request held high in DONE is ignored for that cycle. If still high in IDLE, it is sampled at the next edge and a new sweep starts.
- During SWEEP:
  - w_en is ignored and bypass is disabled.
  - Reads return current stored contents: registers already swept read 0, unswept registers keep their old values.
- Writes are accepted again in DONE, and a write there is not overwritten.
- Reset asserted mid-sweep aborts immediately: IDLE, all registers 0, no clr_done pulse.
- Width rules: w_in is stored unmodified and there is no sign or zero extension. Addresses are full-range, so there are no out-of-range cases.

Test Plan:
- Reset then read: assert reset, release, src0=0..7 and src1=7..0 -> op0=op1=16'h0000 for every address; clr_busy=0, clr_done=0.
- Write/readback: write reg[3]=16'hBEEF and reg[5]=16'h1234 (w_en=1). Next cycle src0=3, src1=5 -> op0=16'hBEEF, op1=16'h1234. Write with w_en=0 to reg[3]=16'h0000 -> reg[3] stays 16'hBEEF.
- Bypass: BYPASS=1, dest=2, w_in=16'hA5A5, w_en=1, src0=2 in the same cycle -> op0=16'hA5A5 before the edge. With BYPASS=0 -> op0 shows the old value, then 16'hA5A5 after the edge.
- Zero R0: ZERO_R0=1, write dest=0 w_in=16'hFFFF -> op0 at src0=0 reads 16'h0000. The same write with ZERO_R0=0 reads 16'hFFFF.
- Clear sweep: fill reg[i]=16'h1111*i, pulse clr_req at edge E -> clr_busy high for 8 cycles. reg[4] still 16'h4444 just before edge E+5 and 0 after it. clr_done high for one cycle after E+8. A write to reg[6] during busy is dropped. A write to reg[6]=16'h0606 in the DONE cycle persists.
- Reset mid-sweep: start a sweep, assert reset at cycle 3 of busy -> clr_busy=0 immediately, no clr_done pulse, all regs read 0, and a new clr_req after release runs a full 8-cycle sweep.
